// File: rtl/piradip_sample_buffer_pkg.sv
// Shared types and helpers for the sample buffer playback and capture engines.
package piradip_sample_buffer_pkg;

   typedef enum logic [1:0] {
      PB_IDLE,
      PB_ARMED,
      PB_RUN,
      PB_DRAIN
   } playback_state_t;

   // Window advance: wrap to first once addr reaches or passes last.
   function automatic logic [31:0] next_offset(input logic [31:0] addr,
                                               input logic [31:0] first,
                                               input logic [31:0] last);
      return (addr >= last) ? first : addr + 32'd1;
   endfunction

endpackage

// File: rtl/piradip_sample_playback_fifo.sv
// Synchronous output FIFO for the playback engine; head is visible combinationally.
module piradip_sample_playback_fifo #(
   parameter int WIDTH       = 65,
   parameter int DEPTH       = 3,
   parameter int COUNT_WIDTH = $clog2(DEPTH + 1)
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head,
   output logic [COUNT_WIDTH-1:0] count
);

   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   assign head = mem[rd_ptr];

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/piradip_sample_playback_engine.sv
// Stream-side playback engine: RAM port B reader feeding an AXI4-Stream master.
// Optional start trigger enabled by defining PIRADIP_PLAYBACK_TRIGGER_EN.
module piradip_sample_playback_engine #(
   parameter int DATA_WIDTH   = 64,
   parameter int ADDR_WIDTH   = 12,
   parameter int READ_LATENCY = 1,
   parameter int FIFO_DEPTH   = READ_LATENCY + 2
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  ctrl_update,
   input  logic                  ctrl_active,
   input  logic                  ctrl_one_shot,
   input  logic [ADDR_WIDTH-1:0] ctrl_start_offset,
   input  logic [ADDR_WIDTH-1:0] ctrl_end_offset,
   output logic                  ctrl_running,
   output logic                  ctrl_stopped,
`ifdef PIRADIP_PLAYBACK_TRIGGER_EN
   input  logic                  trigger,
`endif
   output logic                  mem_en,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic [DATA_WIDTH-1:0] m_tdata,
   output logic                  m_tvalid,
   input  logic                  m_tready,
   output logic                  m_tlast
);

   import piradip_sample_buffer_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   playback_state_t       state;
   logic [ADDR_WIDTH-1:0] pend_start, pend_end, win_end, ptr;
   logic [ADDR_WIDTH-1:0] nxt_start, nxt_end;
   logic                  pend_one_shot, one_shot, nxt_one_shot;
   logic                  mem_last, rearm;
   logic [READ_LATENCY-1:0] pipe_v, pipe_l;
   logic [CW-1:0]         fifo_count;
   logic [DATA_WIDTH:0]   head;
   logic                  pop, trig_ok, issue, drained, wrap, stop_req, arm_req;
   int unsigned           used;

`ifdef PIRADIP_PLAYBACK_TRIGGER_EN
   assign trig_ok = trigger;
`else
   assign trig_ok = 1'b1;
`endif

   assign stop_req = ctrl_update & ~ctrl_active;
   assign arm_req  = ctrl_update & ctrl_active;
   assign pop      = m_tvalid & m_tready;
   assign wrap     = (ptr >= win_end);

   // An update in the same cycle as a wrap takes effect at that wrap.
   assign nxt_start    = arm_req ? ctrl_start_offset : pend_start;
   assign nxt_end      = arm_req ? ctrl_end_offset   : pend_end;
   assign nxt_one_shot = arm_req ? ctrl_one_shot     : pend_one_shot;

   // Credits count the address stage, the read pipe and the FIFO; a pop this
   // cycle frees a slot so the stream sustains one word per cycle.
   always_comb begin
      used = 32'(mem_en) + 32'(fifo_count);
      for (int unsigned i = 0; i < READ_LATENCY; i++) used += 32'(pipe_v[i]);
      issue   = (state == PB_RUN) && !stop_req && (used < unsigned'(FIFO_DEPTH) + 32'(pop));
      drained = (used == 0);
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state         <= PB_IDLE;
         mem_en        <= 1'b0;
         mem_addr      <= '0;
         mem_last      <= 1'b0;
         pipe_v        <= '0;
         pipe_l        <= '0;
         ctrl_stopped  <= 1'b0;
         rearm         <= 1'b0;
         ptr           <= '0;
         win_end       <= '0;
         one_shot      <= 1'b0;
         pend_start    <= '0;
         pend_end      <= '0;
         pend_one_shot <= 1'b0;
      end else begin
         ctrl_stopped <= 1'b0;
         mem_en       <= 1'b0;
         pipe_v[0]    <= mem_en;
         pipe_l[0]    <= mem_last;
         for (int unsigned i = 1; i < READ_LATENCY; i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_l[i] <= pipe_l[i-1];
         end
         if (arm_req) begin
            pend_start    <= ctrl_start_offset;
            pend_end      <= ctrl_end_offset;
            pend_one_shot <= ctrl_one_shot;
         end
         case (state)
            PB_IDLE: begin
               if (rearm || arm_req) state <= PB_ARMED;
               rearm <= 1'b0;
            end
            PB_ARMED: begin
               if (stop_req) begin
                  state        <= PB_IDLE;
                  ctrl_stopped <= 1'b1;
               end else if (trig_ok) begin
                  state    <= PB_RUN;
                  ptr      <= nxt_start;
                  win_end  <= nxt_end;
                  one_shot <= nxt_one_shot;
               end
            end
            PB_RUN: begin
               if (stop_req) begin
                  state <= PB_DRAIN;
               end else if (issue) begin
                  mem_en   <= 1'b1;
                  mem_addr <= ptr;
                  mem_last <= (ptr == win_end);
                  ptr      <= ADDR_WIDTH'(next_offset(32'(ptr), 32'(nxt_start), 32'(win_end)));
                  if (wrap) begin
                     win_end  <= nxt_end;
                     one_shot <= nxt_one_shot;
                     if (one_shot) state <= PB_DRAIN;
                  end
               end
            end
            PB_DRAIN: begin
               if (drained) begin
                  state        <= PB_IDLE;
                  ctrl_stopped <= 1'b1;
                  rearm        <= arm_req;
               end
            end
            default: state <= PB_IDLE;
         endcase
      end
   end

   piradip_sample_playback_fifo #(
      .WIDTH       (DATA_WIDTH + 1),
      .DEPTH       (FIFO_DEPTH),
      .COUNT_WIDTH (CW)
   ) u_fifo (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .push      (pipe_v[READ_LATENCY-1]),
      .push_data ({pipe_l[READ_LATENCY-1], mem_rdata}),
      .pop       (pop),
      .head      (head),
      .count     (fifo_count)
   );

   assign m_tvalid     = (fifo_count != '0);
   assign m_tdata      = head[DATA_WIDTH-1:0];
   assign m_tlast      = m_tvalid & head[DATA_WIDTH];
   assign ctrl_running = (state != PB_IDLE);

endmodule
